booth_seq_mul: RTL
==================

Name: booth_seq_mul

Overview:
Parametrised iterative radix-4 Booth multiplier; successor to the fixed 16-bit combinational partial-product unit.
Retires one Booth digit per clock into a shared accumulator. Supports signed or unsigned operands per transaction.
Uses valid/ready handshakes on both sides. Sits between operand staging and the datapath result bus.

Parameters:
WIDTH, 16, operand width in bits; must be even and >= 4
DIGITS, WIDTH/2+1, derived localparam: number of Booth digits processed (one extra digit covers the unsigned top bit)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands
is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
multiplicand  in  WIDTH  operand A
multiplier  in  WIDTH  operand B (Booth-recoded)
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
product  out  2*WIDTH  A*B, exact

Behaviour:
- Reset: state IDLE; in_ready=1, out_valid=0, product=0; counter and accumulator cleared. Reset mid-operation abandons the transaction; no output is produced.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch the operands, extended to WIDTH+2 bits (sign-extended if is_signed, else zero-extended). Clear acc and cnt; go to CALC.
  - CALC: in_ready=0. Each edge recodes digit cnt from multiplier bits {b[2cnt+1], b[2cnt], b[2cnt-1]} with b[-1]=0. Digit set is 0, +1, +2, -1, -2.
    - pp = selected multiple of the extended multiplicand, WIDTH+3 bits, sign-extended.
    - Negative digits use full two's-complement negation (invert plus 1); no deferred +1 correction term.
    - acc (2*WIDTH+4 bits) += pp sign-extended << 2*cnt; cnt++.
    - After the edge processing cnt=DIGITS-1, go to DONE.
  - DONE: out_valid=1, product = acc[2*WIDTH-1:0], held stable. On out_valid&out_ready, go to IDLE with out_valid=0.
- Latency: out_valid is high DIGITS edges after the accepting edge (9 for WIDTH=16).
- Throughput: one transaction per DIGITS+2 cycles, because in_ready is low in CALC and DONE.
- Inputs other than out_ready are ignored outside IDLE. is_signed, multiplicand and multiplier changing during CALC have no effect.
- Backpressure: DONE holds indefinitely while out_ready=0; product does not change.
- Correctness: product equals the mathematical product for every operand pair in both modes. This includes signed -2^(WIDTH-1) * -2^(WIDTH-1) and unsigned (2^WIDTH-1)^2.
- Digit 0 (zero multiple) adds nothing. The accumulator is never saturated, since its width is sufficient.

Decomposition:
- Package booth_pkg:
  - state enum {IDLE, CALC, DONE};
  - Booth digit encoding type (sel_zero, sel_one, sel_two, neg fields);
  - function for DIGITS from WIDTH.
- Sub-module booth_pp_sel (combinational, parametrised by WIDTH): takes a 3-bit recode window and the extended multiplicand; returns the WIDTH+3-bit signed partial product. It is the generalised successor of the fixed partial-product selector.
- FSM, counter and accumulator live in booth_seq_mul.

Test Plan:
- WIDTH=16, signed, A=0xFFFF, B=0xFFFF -> product=0x0000_0001; out_valid 9 cycles after accept.
- WIDTH=16, signed, A=0x8000, B=0x8000 -> product=0x4000_0000; also A=0x8000, B=0x7FFF -> 0xC000_8000.
- WIDTH=16, unsigned, A=0xFFFF, B=0xFFFF -> 0xFFFE_0001; A=0x1234, B=0x0000 -> 0x0000_0000.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> product stable, in_ready=0 throughout; out_ready=1 -> next cycle IDLE, in_ready=1.
- Reset at CALC cycle 4 -> next cycle in_ready=1, out_valid=0. A following transaction (signed 3 * -5) returns 0xFFFF_FFF1 with no stale data.
- Random 10k signed/unsigned pairs at WIDTH=8, 16 and 32 against a reference model, with random in_valid/out_ready gaps -> all match, with no dropped or duplicated results.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
//   state_e        : controller states
//   booth_digit_t  : one-hot-ish decode of a radix-4 Booth digit
//   booth_digits() : number of Booth digits retired for a given operand width
//   booth_recode() : 3-bit window {b[2i+1], b[2i], b[2i-1]} -> digit decode
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Digit magnitude select plus sign; exactly one of sel_zero/sel_one/sel_two is set.
  typedef struct packed {
    logic sel_zero;
    logic sel_one;
    logic sel_two;
    logic neg;
  } booth_digit_t;

  // One extra digit beyond WIDTH/2 absorbs the zero-extended top bit of unsigned operands.
  function automatic int unsigned booth_digits(input int unsigned width);
    return width / 2 + 1;
  endfunction

  // Standard radix-4 recode: digit = -2*b[2i+1] + b[2i] + b[2i-1].
  function automatic booth_digit_t booth_recode(input logic [2:0] win);
    booth_digit_t d;
    d = '0;
    case (win)
      3'b000, 3'b111: d.sel_zero = 1'b1;
      3'b001, 3'b010: d.sel_one  = 1'b1;
      3'b011:         d.sel_two  = 1'b1;
      3'b100: begin
        d.sel_two = 1'b1;
        d.neg     = 1'b1;
      end
      3'b101, 3'b110: begin
        d.sel_one = 1'b1;
        d.neg     = 1'b1;
      end
      default: d.sel_zero = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_seq_mul_if.sv
// Operand/result handshake bundle for booth_seq_mul.
//   in_valid/in_ready          : operand handshake (producer -> multiplier)
//   is_signed, multiplicand,
//   multiplier                 : operand payload, sampled on in_valid & in_ready
//   out_valid/out_ready        : result handshake (multiplier -> consumer)
//   product                    : exact 2*WIDTH-bit product
interface booth_seq_mul_if #(
  parameter int unsigned WIDTH = 16
);

  logic                 in_valid;
  logic                 in_ready;
  logic                 is_signed;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  // Operand stager / result consumer side.
  modport master (
    output in_valid,
    output is_signed,
    output multiplicand,
    output multiplier,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product
  );

  // Multiplier side.
  modport slave (
    input  in_valid,
    input  is_signed,
    input  multiplicand,
    input  multiplier,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product
  );

endinterface

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth partial-product selector (combinational).
//   win   : 3-bit recode window {b[2i+1], b[2i], b[2i-1]}
//   mcand : multiplicand already extended to WIDTH+2 bits (sign or zero)
//   pp_c  : signed partial product, WIDTH+3 bits, in {0, +-1, +-2} * mcand
module booth_pp_sel
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [2:0]       win,
  input  logic [WIDTH+1:0] mcand,
  output logic [WIDTH+2:0] pp_c
);

  localparam int unsigned PP_W = WIDTH + 3;

  booth_digit_t    dig;
  logic [PP_W-1:0] mag;

  // Select magnitude, then apply full two's-complement negation for negative digits.
  always_comb begin
    dig = booth_recode(win);
    mag = '0;
    if (dig.sel_zero) begin
      mag = '0;
    end else if (dig.sel_one) begin
      mag = {mcand[WIDTH+1], mcand};
    end else if (dig.sel_two) begin
      mag = {mcand, 1'b0};
    end
    pp_c = dig.neg ? (~mag + PP_W'(1)) : mag;
  end

endmodule

// File: rtl/booth_seq_mul.sv
// Iterative radix-4 Booth multiplier: one Booth digit retired per clock into a
// shared accumulator; signed or unsigned operands selected per transaction.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset; abandons any transaction in flight
//   bus  : booth_seq_mul_if slave -- operand handshake in, product handshake out
module booth_seq_mul
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  booth_seq_mul_if.slave bus
);

  localparam int unsigned DIGITS = booth_digits(WIDTH);
  localparam int unsigned EXT_W  = WIDTH + 2;
  localparam int unsigned PP_W   = WIDTH + 3;
  localparam int unsigned ACC_W  = 2 * WIDTH + 4;
  localparam int unsigned CNT_W  = $clog2(DIGITS);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [EXT_W-1:0]   mcand_q, mcand_d;
  logic [EXT_W-1:0]   mult_q, mult_d;
  logic               in_ready_q;
  logic               out_valid_q;

  logic               a_sx;
  logic               b_sx;
  logic [EXT_W:0]     mult_pad;
  logic [2:0]         win;
  logic [PP_W-1:0]    pp;
  logic [ACC_W-1:0]   pp_ext;
  logic [ACC_W-1:0]   pp_shl;

  // Appending b[-1]=0 below the multiplier makes window i start at bit 2i.
  assign mult_pad = {mult_q, 1'b0};
  assign win      = mult_pad[{cnt_q, 1'b0} +: 3];

  booth_pp_sel #(
    .WIDTH (WIDTH)
  ) u_pp_sel (
    .win   (win),
    .mcand (mcand_q),
    .pp_c  (pp)
  );

  // Weight the partial product by 4^cnt in accumulator width.
  assign pp_ext = {{(ACC_W - PP_W){pp[PP_W-1]}}, pp};
  assign pp_shl = pp_ext << {cnt_q, 1'b0};

  // Operand extension: two guard bits keep unsigned values positive under Booth.
  assign a_sx = bus.is_signed & bus.multiplicand[WIDTH-1];
  assign b_sx = bus.is_signed & bus.multiplier[WIDTH-1];

  // Next-state, counter and accumulator update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          mcand_d = {{2{a_sx}}, bus.multiplicand};
          mult_d  = {{2{b_sx}}, bus.multiplier};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + pp_shl;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIGITS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; handshake outputs registered from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mult_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mult_q      <= mult_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  // Accumulator only changes in CALC, so the product is stable throughout DONE.
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = acc_q[2*WIDTH-1:0];

endmodule
